paint_canvas: RTL and testbench

Parametrised, clock-enabled paint canvas: stores a GRID_DIM×GRID_DIM cell map of palette codes, paints cells from mouse clicks, serves a registered render-read port for the OLED pixel path, and streams a binary raster of the canvas to the digit-recognition network over a valid/ready handshake. It sits between the mouse/palette logic and both the display colour mux and the neural-network input. It replaces ad-hoc multi-clock painting with a single-clock FSM that adds sweep-clear, scan arbitration and an optional multi-cell brush.

---
 rtl/paint_pkg.sv | 47 ++++
 rtl/paint_cell_addr.sv | 38 +++
 rtl/paint_canvas.sv | 279 +++++++++++++++++++++++++++
 tb/tb_paint_canvas.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// -----------------------------------------------------------------------------
// paint_pkg
// Shared definitions for the paint canvas slice:
//   - palette codes (BLANK is the "unpainted" code; everything else is ink)
//   - RGB565 colour for each palette code, used by the display colour mux
//   - FSM state encoding for paint_canvas (BRUSH exists only when
//     PAINT_CANVAS_BRUSH_EN is defined)
// -----------------------------------------------------------------------------
package paint_pkg;

    typedef enum logic [2:0] {
        BLANK  = 3'd0,
        BLUE   = 3'd1,
        GREEN  = 3'd2,
        RED    = 3'd3,
        ORANGE = 3'd4
    } palette_e;

    localparam logic [15:0] RGB_BLANK  = 16'h0000;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_ORANGE = 16'hFC00;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        SCAN  = 2'd2
`ifdef PAINT_CANVAS_BRUSH_EN
        ,BRUSH = 2'd3
`endif
    } state_e;

    // Map a palette code to its RGB565 pixel value; unknown codes render black.
    function automatic logic [15:0] palette_rgb(input logic [2:0] code);
        logic [15:0] rgb;
        case (code)
            BLUE:    rgb = RGB_BLUE;
            GREEN:   rgb = RGB_GREEN;
            RED:     rgb = RGB_RED;
            ORANGE:  rgb = RGB_ORANGE;
            default: rgb = RGB_BLANK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/paint_cell_addr.sv
// -----------------------------------------------------------------------------
// paint_cell_addr
// Converts a screen pixel coordinate into a linear cell index of the canvas
// cell map, plus a flag saying whether the pixel lies on the canvas at all.
// Division is by the constant CELL_PX, so it reduces to fixed logic.
//
// Ports:
//   px_x, px_y  in  IN_W   pixel coordinate
//   cell_idx    out IDX_W  (px_y/CELL_PX)*GRID_DIM + px_x/CELL_PX
//                          (only meaningful when in_canvas = 1)
//   in_canvas   out 1      px_x < CANVAS_PX and px_y < CANVAS_PX
// -----------------------------------------------------------------------------
module paint_cell_addr
    import paint_pkg::*;
#(
    parameter int IN_W      = 12,
    parameter int CANVAS_PX = 56,
    parameter int CELL_PX   = 3,
    parameter int GRID_DIM  = 19,
    parameter int IDX_W     = $clog2(GRID_DIM * GRID_DIM)
) (
    input  logic [IN_W-1:0]  px_x,
    input  logic [IN_W-1:0]  px_y,
    output logic [IDX_W-1:0] cell_idx,
    output logic             in_canvas
);

    localparam logic [IN_W-1:0]  CANVAS_LIM = IN_W'(CANVAS_PX);
    localparam logic [IN_W-1:0]  CELL_DIV   = IN_W'(CELL_PX);
    localparam logic [IDX_W-1:0] GRID_MUL   = IDX_W'(GRID_DIM);

    assign in_canvas = (px_x < CANVAS_LIM) && (px_y < CANVAS_LIM);

    // Off-canvas coordinates truncate to a meaningless index; callers gate
    // every use with in_canvas.
    assign cell_idx = IDX_W'(px_y / CELL_DIV) * GRID_MUL + IDX_W'(px_x / CELL_DIV);

endmodule

// File: rtl/paint_canvas.sv
// -----------------------------------------------------------------------------
// paint_canvas
// GRID_DIM x GRID_DIM cell map of palette codes. Paints cells from mouse
// clicks, serves a registered render-read port for the OLED pixel path and
// streams a binary raster of the canvas over a valid/ready handshake.
//
// Optional feature macro: PAINT_CANVAS_BRUSH_EN
//   defined   - a paint request enters BRUSH and writes centre, N, S, W, E
//   undefined - a paint request writes a single cell directly from IDLE
//
// Ports:
//   clk_100M, reset            clock, asynchronous active-high reset
//   enable                     0 suppresses painting only
//   mouse_l                    left button (asynchronous, synchronised here)
//   mouse_x, mouse_y           cursor pixel position
//   colour_sel                 palette code written by a paint
//   clear_req, scan_start      one-cycle request pulses (latched as pending)
//   rd_x, rd_y -> rd_colour, rd_in_canvas   render read, 1-cycle latency
//   scan_valid/scan_ready, scan_x/y, scan_bit, scan_last   raster stream
//   busy                       FSM not in IDLE
// -----------------------------------------------------------------------------
module paint_canvas
    import paint_pkg::*;
#(
    parameter int CANVAS_PX = 56,
    parameter int CELL_PX   = 3,
    parameter int GRID_DIM  = 19,
    parameter int COLOUR_W  = 3,
    parameter int COORD_W   = 12
) (
    input  logic                clk_100M,
    input  logic                reset,
    input  logic                enable,
    input  logic                mouse_l,
    input  logic [COORD_W-1:0]  mouse_x,
    input  logic [COORD_W-1:0]  mouse_y,
    input  logic [COLOUR_W-1:0] colour_sel,
    input  logic                clear_req,
    input  logic [6:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                rd_in_canvas,
    input  logic                scan_start,
    output logic                scan_valid,
    input  logic                scan_ready,
    output logic [9:0]          scan_x,
    output logic [9:0]          scan_y,
    output logic                scan_bit,
    output logic                scan_last,
    output logic                busy
);

    localparam int CELLS = GRID_DIM * GRID_DIM;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
    localparam logic [9:0]       SCAN_MAX = 10'(CANVAS_PX - 1);

    state_e              state_reg;
    logic [IDX_W-1:0]    sweep_reg;
    logic [1:0]          mouse_sync_reg;   // [0] metastable stage, [1] usable
    logic                clear_pend_reg;
    logic                scan_pend_reg;

    logic [COLOUR_W-1:0] mem [0:CELLS-1];

    // ---------------------------------------------------------------- write path
    logic [IDX_W-1:0] paint_idx;
    logic             paint_in;

    paint_cell_addr #(
        .IN_W(COORD_W), .CANVAS_PX(CANVAS_PX), .CELL_PX(CELL_PX),
        .GRID_DIM(GRID_DIM), .IDX_W(IDX_W)
    ) u_paint_addr (
        .px_x(mouse_x), .px_y(mouse_y), .cell_idx(paint_idx), .in_canvas(paint_in)
    );

    logic paint_req, take_clear, take_scan, take_paint;
    assign paint_req  = mouse_sync_reg[1] & enable & paint_in;
    // IDLE arbitration: pending clear beats pending scan beats painting.
    assign take_clear = (state_reg == IDLE) & clear_pend_reg;
    assign take_scan  = (state_reg == IDLE) & ~clear_pend_reg & scan_pend_reg;
    assign take_paint = (state_reg == IDLE) & ~clear_pend_reg & ~scan_pend_reg & paint_req;

`ifdef PAINT_CANVAS_BRUSH_EN
    localparam logic [IDX_W-1:0] GRID_I   = IDX_W'(GRID_DIM);
    localparam logic [IDX_W-1:0] BOT_ROW  = IDX_W'(CELLS - GRID_DIM);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(GRID_DIM - 1);

    logic [2:0]          brush_step_reg;
    logic [IDX_W-1:0]    brush_centre_reg;
    logic [COLOUR_W-1:0] brush_colour_reg;
    logic [IDX_W-1:0]    brush_col;
    logic [IDX_W-1:0]    brush_tgt;
    logic                brush_ok;

    assign brush_col = brush_centre_reg % GRID_I;

    // Neighbour that falls off the grid keeps its cycle but writes nothing.
    always_comb begin
        brush_tgt = brush_centre_reg;
        brush_ok  = 1'b1;
        case (brush_step_reg)
            3'd1: begin brush_tgt = brush_centre_reg - GRID_I; brush_ok = (brush_centre_reg >= GRID_I); end
            3'd2: begin brush_tgt = brush_centre_reg + GRID_I; brush_ok = (brush_centre_reg < BOT_ROW);  end
            3'd3: begin brush_tgt = brush_centre_reg - 1'b1;   brush_ok = (brush_col != '0);           end
            3'd4: begin brush_tgt = brush_centre_reg + 1'b1;   brush_ok = (brush_col != LAST_COL);     end
            default: begin brush_tgt = brush_centre_reg; brush_ok = 1'b1; end
        endcase
    end
`endif

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [COLOUR_W-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sweep_reg;
        wr_data = '0;
        if (state_reg == CLEAR) begin
            wr_en = 1'b1;
        end
`ifdef PAINT_CANVAS_BRUSH_EN
        else if (state_reg == BRUSH) begin
            wr_en   = brush_ok;
            wr_idx  = brush_tgt;
            wr_data = brush_colour_reg;
        end
`else
        else if (take_paint) begin
            wr_en   = 1'b1;
            wr_idx  = paint_idx;
            wr_data = colour_sel;
        end
`endif
    end

    always_ff @(posedge clk_100M) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // ---------------------------------------------------------------- render port
    logic [IDX_W-1:0] rd_idx;
    logic             rd_in;

    paint_cell_addr #(
        .IN_W(7), .CANVAS_PX(CANVAS_PX), .CELL_PX(CELL_PX),
        .GRID_DIM(GRID_DIM), .IDX_W(IDX_W)
    ) u_rd_addr (
        .px_x(rd_x), .px_y(rd_y), .cell_idx(rd_idx), .in_canvas(rd_in)
    );

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            rd_colour    <= '0;
            rd_in_canvas <= 1'b0;
        end else begin
            rd_in_canvas <= rd_in;
            rd_colour    <= rd_in ? mem[rd_idx] : '0;
        end
    end

    // ---------------------------------------------------------------- scan source
    // load_x/y is the coordinate the output registers take next: the current
    // one on the first SCAN cycle (nothing presented yet), else the successor.
    logic [9:0]       load_x, load_y;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_in;

    always_comb begin
        load_x = scan_x;
        load_y = scan_y;
        if (scan_valid) begin
            if (scan_x == SCAN_MAX) begin
                load_x = '0;
                load_y = scan_y + 10'd1;
            end else begin
                load_x = scan_x + 10'd1;
            end
        end
    end

    paint_cell_addr #(
        .IN_W(10), .CANVAS_PX(CANVAS_PX), .CELL_PX(CELL_PX),
        .GRID_DIM(GRID_DIM), .IDX_W(IDX_W)
    ) u_scan_addr (
        .px_x(load_x), .px_y(load_y), .cell_idx(scan_idx), .in_canvas(scan_in)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            state_reg      <= CLEAR;
            sweep_reg      <= '0;
            mouse_sync_reg <= '0;
            clear_pend_reg <= 1'b0;
            scan_pend_reg  <= 1'b0;
            scan_valid     <= 1'b0;
            scan_x         <= '0;
            scan_y         <= '0;
            scan_bit       <= 1'b0;
            scan_last      <= 1'b0;
`ifdef PAINT_CANVAS_BRUSH_EN
            brush_step_reg   <= '0;
            brush_centre_reg <= '0;
            brush_colour_reg <= '0;
`endif
        end else begin
            mouse_sync_reg <= {mouse_sync_reg[0], mouse_l};
            // A new pulse always wins over the consume, so nothing is lost.
            clear_pend_reg <= clear_req  | (clear_pend_reg & ~take_clear);
            scan_pend_reg  <= scan_start | (scan_pend_reg & ~take_scan);

            case (state_reg)
                CLEAR: begin
                    if (sweep_reg == LAST_IDX) begin
                        sweep_reg <= '0;
                        state_reg <= IDLE;
                    end else begin
                        sweep_reg <= sweep_reg + 1'b1;
                    end
                end

                IDLE: begin
                    if (take_clear) begin
                        state_reg <= CLEAR;
                    end else if (take_scan) begin
                        state_reg  <= SCAN;
                        scan_x     <= '0;
                        scan_y     <= '0;
                        scan_valid <= 1'b0;
                        scan_last  <= 1'b0;
                    end
`ifdef PAINT_CANVAS_BRUSH_EN
                    else if (take_paint) begin
                        state_reg        <= BRUSH;
                        brush_step_reg   <= '0;
                        brush_centre_reg <= paint_idx;
                        brush_colour_reg <= colour_sel;
                    end
`endif
                end

                SCAN: begin
                    if (!scan_valid || scan_ready) begin
                        if (scan_valid && scan_last) begin
                            scan_valid <= 1'b0;
                            scan_last  <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            scan_valid <= 1'b1;
                            scan_x     <= load_x;
                            scan_y     <= load_y;
                            scan_bit   <= scan_in & (mem[scan_idx] != '0);
                            scan_last  <= (load_x == SCAN_MAX) && (load_y == SCAN_MAX);
                        end
                    end
                end

`ifdef PAINT_CANVAS_BRUSH_EN
                BRUSH: begin
                    if (brush_step_reg == 3'd4) begin
                        state_reg <= IDLE;
                    end else begin
                        brush_step_reg <= brush_step_reg + 3'd1;
                    end
                end
`endif

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_paint_canvas.sv
// -----------------------------------------------------------------------------
// tb_paint_canvas
// Self-checking bench for paint_canvas: table-driven paint/render vectors plus
// hand-written sequences for sweep clear, button latency, raster scan with
// back-pressure, clear/scan arbitration and reset during a scan.
// Brush-specific checks are compiled in with PAINT_CANVAS_BRUSH_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_paint_canvas;

    localparam int CPX  = 56;
    localparam int CELL = 3;
    localparam int GRID = 19;

    logic        clk_100M = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mouse_l = 1'b0;
    logic [11:0] mouse_x = '0, mouse_y = '0;
    logic [2:0]  colour_sel = '0;
    logic        clear_req = 1'b0;
    logic [6:0]  rd_x = '0, rd_y = '0;
    logic [2:0]  rd_colour;
    logic        rd_in_canvas;
    logic        scan_start = 1'b0;
    logic        scan_valid;
    logic        scan_ready = 1'b0;
    logic [9:0]  scan_x, scan_y;
    logic        scan_bit, scan_last, busy;

    paint_canvas dut (
        .clk_100M(clk_100M), .reset(reset), .enable(enable), .mouse_l(mouse_l),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .colour_sel(colour_sel),
        .clear_req(clear_req), .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
        .rd_in_canvas(rd_in_canvas), .scan_start(scan_start), .scan_valid(scan_valid),
        .scan_ready(scan_ready), .scan_x(scan_x), .scan_y(scan_y), .scan_bit(scan_bit),
        .scan_last(scan_last), .busy(busy)
    );

    always #5 clk_100M = ~clk_100M;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------------------------------------------------------- model
    int model [0:GRID*GRID-1];

    function automatic int cell_of(input int x, input int y);
        return (y / CELL) * GRID + x / CELL;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < GRID*GRID; i++) model[i] = 0;
    endtask

    task automatic model_paint(input int x, input int y, input int c);
        int r, col;
        if (x < CPX && y < CPX) begin
            r = y / CELL; col = x / CELL;
            model[r*GRID + col] = c;
`ifdef PAINT_CANVAS_BRUSH_EN
            if (r > 0)        model[(r-1)*GRID + col] = c;
            if (r < GRID-1)   model[(r+1)*GRID + col] = c;
            if (col > 0)      model[r*GRID + col - 1] = c;
            if (col < GRID-1) model[r*GRID + col + 1] = c;
`endif
        end
    endtask

    function automatic bit exp_bit(input int x, input int y);
        return model[cell_of(x, y)] != 0;
    endfunction

    // Hold the button long enough for synchroniser and (optional) brush.
    task automatic press(input int x, input int y, input int c);
        mouse_x = 12'(x); mouse_y = 12'(y); colour_sel = 3'(c); enable = 1'b1;
        mouse_l = 1'b1;
        repeat (8) @(negedge clk_100M);
        mouse_l = 1'b0;
        repeat (10) @(negedge clk_100M);
        model_paint(x, y, c);
    endtask

    // ---------------------------------------------------------------- scan sink
    int s_beats, s_bad, s_stall, s_last;

    task automatic run_scan(input bit toggle);
        int ex = 0, ey = 0, k = 0;
        bit done = 1'b0, prev_stall = 1'b0;
        logic [9:0] px = '0, py = '0;
        logic pb = 1'b0, pl = 1'b0;
        s_beats = 0; s_bad = 0; s_stall = 0; s_last = 0;
        while (!done && k < 20000) begin
            scan_ready = toggle ? k[0] : 1'b1;
            if (scan_valid) begin
                if (prev_stall && (scan_x != px || scan_y != py || scan_bit != pb || scan_last != pl))
                    s_stall++;
                if (int'(scan_x) != ex || int'(scan_y) != ey || scan_bit != exp_bit(ex, ey) ||
                    scan_last != (ex == CPX-1 && ey == CPX-1))
                    s_bad++;
                px = scan_x; py = scan_y; pb = scan_bit; pl = scan_last;
                if (scan_ready) begin
                    s_beats++;
                    if (scan_last) begin s_last++; done = 1'b1; end
                    if (ex == CPX-1) begin ex = 0; ey++; end else ex++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                end
            end
            @(negedge clk_100M);
            k++;
        end
        scan_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int mx, my, colour;
        bit en, pr;
        int rdx, rdy, exp_col;
        bit exp_in;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, k, lat;

        //          mx  my  col en pr  rdx  rdy exp in
        vecs[0]  = '{ 7,  4, 3, 1, 1,   8,   5, 3, 1};
        vecs[1]  = '{ 0,  0, 0, 1, 0,  60,   0, 0, 0};
        vecs[2]  = '{30, 30, 2, 0, 1,  30,  30, 0, 1};
        vecs[3]  = '{56,  0, 4, 1, 1,  55,   0, 0, 1};
        vecs[4]  = '{ 0, 56, 4, 1, 1,   0,  55, 0, 1};
        vecs[5]  = '{55, 55, 4, 1, 1,  54,  54, 4, 1};
        vecs[6]  = '{ 0,  0, 0, 1, 0,  12,   5, 0, 1};
        vecs[7]  = '{ 7,  4, 2, 1, 1,   6,   3, 2, 1};
        vecs[8]  = '{ 0,  0, 0, 1, 0,  56,  56, 0, 0};
        vecs[9]  = '{ 0,  0, 0, 1, 0, 127, 127, 0, 0};
        vecs[10] = '{ 0,  0, 0, 1, 0,  10,  10, 0, 1};
        vecs[11] = '{ 0,  0, 0, 1, 0,   0,   0, 0, 1};

        model_clear();

        // ---- reset state
        #12;
        check("reset_busy", int'(busy), 1);
        check("reset_valid", int'(scan_valid), 0);
        check("reset_last", int'(scan_last), 0);
        check("reset_rd_colour", int'(rd_colour), 0);
        check("reset_rd_in", int'(rd_in_canvas), 0);

        // ---- sweep clear
        @(negedge clk_100M);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 360; i++) begin
            @(negedge clk_100M);
            if (!busy) cnt++;
        end
        check("sweep_busy_low_cycles", cnt, 0);
        repeat (2) @(negedge clk_100M);
        check("sweep_done_busy", int'(busy), 0);
        rd_x = 7'd10; rd_y = 7'd10;
        @(negedge clk_100M);
        check("post_clear_rd_colour", int'(rd_colour), 0);
        check("post_clear_rd_in", int'(rd_in_canvas), 1);
        $display("sweep clear: busy=%0d rd(10,10)=%0d", busy, rd_colour);

        // ---- button-to-write latency at (40,40), cell 13*19+13
`ifdef PAINT_CANVAS_BRUSH_EN
        lat = 5;
`else
        lat = 4;
`endif
        rd_x = 7'd40; rd_y = 7'd40;
        mouse_x = 12'd40; mouse_y = 12'd40; colour_sel = 3'd1; enable = 1'b1;
        @(negedge clk_100M);
        mouse_l = 1'b1;
        repeat (lat - 1) @(negedge clk_100M);
        check("latency_not_early", int'(rd_colour), 0);
        @(negedge clk_100M);
        check("latency_written", int'(rd_colour), 1);
        mouse_l = 1'b0;
        repeat (10) @(negedge clk_100M);
        model_paint(40, 40, 1);
        $display("button latency: rd_colour=%0d after %0d cycles", rd_colour, lat);

        // ---- table-driven paint / render vectors
        for (int i = 0; i < 12; i++) begin
            mouse_x = 12'(vecs[i].mx); mouse_y = 12'(vecs[i].my);
            colour_sel = 3'(vecs[i].colour); enable = vecs[i].en;
            mouse_l = vecs[i].pr;
            repeat (8) @(negedge clk_100M);
            mouse_l = 1'b0;
            repeat (10) @(negedge clk_100M);
            if (vecs[i].pr && vecs[i].en) model_paint(vecs[i].mx, vecs[i].my, vecs[i].colour);
            enable = 1'b1;
            rd_x = 7'(vecs[i].rdx); rd_y = 7'(vecs[i].rdy);
            @(negedge clk_100M);
            check($sformatf("vec%0d_rd_colour", i), int'(rd_colour), vecs[i].exp_col);
            check($sformatf("vec%0d_rd_in", i), int'(rd_in_canvas), int'(vecs[i].exp_in));
            $display("vec %0d: press=%0d en=%0d at (%0d,%0d) rd(%0d,%0d) -> colour=%0d in=%0d",
                     i, vecs[i].pr, vecs[i].en, vecs[i].mx, vecs[i].my,
                     vecs[i].rdx, vecs[i].rdy, rd_colour, rd_in_canvas);
        end

        // ---- explicit clear
        clear_req = 1'b1;
        @(negedge clk_100M);
        clear_req = 1'b0;
        repeat (4) @(negedge clk_100M);
        check("clear_entered_busy", int'(busy), 1);
        k = 0;
        while (busy && k < 1000) begin @(negedge clk_100M); k++; end
        check("clear_finished", int'(busy), 0);
        model_clear();
        rd_x = 7'd8; rd_y = 7'd5;
        @(negedge clk_100M);
        check("clear_wiped_cell21", int'(rd_colour), 0);
        $display("clear: finished after %0d cycles", k + 4);

        // ---- paint (0,0) blue, scan with ready toggling
        press(0, 0, 1);
        scan_start = 1'b1;
        @(negedge clk_100M);
        scan_start = 1'b0;
        run_scan(1'b1);
        check("scan1_beats", s_beats, CPX*CPX);
        check("scan1_bad_beats", s_bad, 0);
        check("scan1_stall_changes", s_stall, 0);
        check("scan1_last_count", s_last, 1);
        check("scan1_valid_drops", int'(scan_valid), 0);
        check("scan1_idle", int'(busy), 0);
        $display("scan toggled-ready: beats=%0d bad=%0d stall_changes=%0d", s_beats, s_bad, s_stall);

        // ---- simultaneous clear and scan: clear runs first
        press(20, 20, 2);
        clear_req = 1'b1; scan_start = 1'b1;
        @(negedge clk_100M);
        clear_req = 1'b0; scan_start = 1'b0;
        model_clear();
        k = 0;
        while (!scan_valid && k < 2000) begin @(negedge clk_100M); k++; end
        check("clear_before_scan", int'(k >= GRID*GRID), 1);
        run_scan(1'b0);
        check("scan2_beats", s_beats, CPX*CPX);
        check("scan2_bad_beats", s_bad, 0);
        check("scan2_last_count", s_last, 1);
        $display("clear+scan: first beat after %0d cycles, beats=%0d bad=%0d", k, s_beats, s_bad);

        // ---- reset in the middle of a scan
        scan_ready = 1'b1;
        scan_start = 1'b1;
        @(negedge clk_100M);
        scan_start = 1'b0;
        cnt = 0; k = 0;
        while (cnt < 100 && k < 2000) begin
            if (scan_valid) cnt++;
            @(negedge clk_100M);
            k++;
        end
        check("midscan_beats_before_reset", cnt, 100);
        reset = 1'b1;
        #1;
        check("midscan_reset_valid", int'(scan_valid), 0);
        check("midscan_reset_busy", int'(busy), 1);
        @(negedge clk_100M);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_100M);
            if (scan_valid) cnt++;
        end
        scan_ready = 1'b0;
        check("midscan_no_more_beats", cnt, 0);
        check("midscan_back_idle", int'(busy), 0);
        $display("reset mid-scan: beats after reset=%0d busy=%0d", cnt, busy);

`ifdef PAINT_CANVAS_BRUSH_EN
        // ---- brush at the top-left corner: N and W are off-grid
        mouse_x = 12'd0; mouse_y = 12'd0; colour_sel = 3'd4; enable = 1'b1;
        mouse_l = 1'b1;
        @(negedge clk_100M);
        mouse_l = 1'b0;
        repeat (6) @(negedge clk_100M);
        check("brush_busy_cycle7", int'(busy), 1);
        @(negedge clk_100M);
        check("brush_idle_cycle8", int'(busy), 0);
        repeat (4) @(negedge clk_100M);
        rd_x = 7'd0; rd_y = 7'd0; @(negedge clk_100M);
        check("brush_cell0", int'(rd_colour), 4);
        rd_x = 7'd0; rd_y = 7'd3; @(negedge clk_100M);
        check("brush_cell19", int'(rd_colour), 4);
        rd_x = 7'd3; rd_y = 7'd0; @(negedge clk_100M);
        check("brush_cell1", int'(rd_colour), 4);
        rd_x = 7'd3; rd_y = 7'd3; @(negedge clk_100M);
        check("brush_cell20", int'(rd_colour), 0);
        rd_x = 7'd6; rd_y = 7'd0; @(negedge clk_100M);
        check("brush_cell2", int'(rd_colour), 0);
        $display("brush corner: cells 0/19/1 checked");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
